// File: rtl/ram_sp_bist_if.sv
// RAM port bundle between the BIST engine (initiator) and the 16 x 8 single-port RAM.
interface ram_sp_bist_if;
  logic [3:0] ram_address;
  logic [7:0] ram_data_in;
  logic       ram_write_en;
  logic [7:0] ram_data_out;

  modport master (
    output ram_address,
    output ram_data_in,
    output ram_write_en,
    input  ram_data_out
  );

  modport slave (
    input  ram_address,
    input  ram_data_in,
    input  ram_write_en,
    output ram_data_out
  );
endinterface

// File: rtl/ram_sp_bist.sv
// Two-pass march BIST for a 16 x 8 synchronous-read RAM: write/read with a seeded
// pattern, then with its complement, counting mismatches and the first failing address.
module ram_sp_bist #(
  parameter logic [7:0] PATTERN = 8'hA5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  ram_sp_bist_if.master       ram,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [5:0]          error_count,
  output logic [3:0]          first_fail_addr,
  output logic                first_fail_valid
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_FLUSH, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        psel, psel_nxt;
  logic        vld_p1;
  logic [3:0]  cmp_addr_p1;
  logic [7:0]  cmp_exp_p1;
  logic        mismatch;
  logic [5:0]  err_upd;

  function automatic logic [7:0] expected(input logic [3:0] a, input logic p);
    logic [7:0] e;
    e = PATTERN ^ {a, a};
    return p ? ~e : e;
  endfunction

  function automatic logic [5:0] sat_inc(input logic [5:0] c);
    return (c == 6'h3F) ? c : c + 6'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      psel  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      psel  <= psel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    psel_nxt  = psel;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_WRITE;
          cnt_nxt   = 4'd0;
          psel_nxt  = 1'b0;
        end
      end
      S_WRITE: begin
        cnt_nxt = cnt + 4'd1;
        if (cnt == 4'd15) state_nxt = S_READ;
      end
      S_READ: begin
        cnt_nxt = cnt + 4'd1;
        if (cnt == 4'd15) begin
          if (psel) begin
            state_nxt = S_FLUSH;
          end else begin
            state_nxt = S_WRITE;
            psel_nxt  = 1'b1;
          end
        end
      end
      S_FLUSH: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Compare stage: data for the address tagged last cycle is on ram_data_out now.
  assign mismatch = vld_p1 && (ram.ram_data_out != cmp_exp_p1);
  assign err_upd  = mismatch ? sat_inc(error_count) : error_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      ram.ram_address  <= 4'd0;
      ram.ram_data_in  <= 8'd0;
      ram.ram_write_en <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      error_count      <= 6'd0;
      first_fail_addr  <= 4'd0;
      first_fail_valid <= 1'b0;
      vld_p1           <= 1'b0;
    end else begin
      ram.ram_address  <= cnt_nxt;
      ram.ram_write_en <= (state_nxt == S_WRITE);
      if (state_nxt == S_WRITE) ram.ram_data_in <= expected(cnt_nxt, psel_nxt);
      busy   <= (state_nxt == S_WRITE) || (state_nxt == S_READ) || (state_nxt == S_FLUSH);
      done   <= (state_nxt == S_DONE);
      vld_p1 <= (state == S_READ);
      if (state == S_IDLE && start) begin
        pass             <= 1'b0;
        error_count      <= 6'd0;
        first_fail_addr  <= 4'd0;
        first_fail_valid <= 1'b0;
      end else begin
        error_count <= err_upd;
        if (mismatch && !first_fail_valid) begin
          first_fail_addr  <= cmp_addr_p1;
          first_fail_valid <= 1'b1;
        end
        // The last compare lands on the same edge that enters DONE, so use err_upd.
        if (state == S_FLUSH) pass <= (err_upd == 6'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    cmp_addr_p1 <= cnt;
    cmp_exp_p1  <= expected(cnt, psel);
  end

endmodule

// File: tb/tb_ram_sp_bist.sv
// Bench for ram_sp_bist: behavioural RAM with injectable read faults, queue of expected
// results per accepted start, and a negedge monitor that checks each done pulse.
module tb_ram_sp_bist;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, pass, first_fail_valid;
  logic [5:0] error_count;
  logic [3:0] first_fail_addr;

  ram_sp_bist_if bus ();

  ram_sp_bist dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .ram              (bus),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .error_count      (error_count),
    .first_fail_addr  (first_fail_addr),
    .first_fail_valid (first_fail_valid)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: registered address, combinational read; fault 1 = bit0 stuck-at-1,
  // fault 2 = flip bit0 when reading address 15 while it holds the pass-1 value 8'hA5.
  logic [7:0] mem [16];
  logic [3:0] addr_q;
  logic [7:0] rd;
  int         fault = 0;

  always @(posedge clk) begin
    if (bus.ram_write_en) mem[bus.ram_address] <= bus.ram_data_in;
    addr_q <= bus.ram_address;
  end

  always_comb begin
    rd = mem[addr_q];
    if (fault == 1) rd[0] = 1'b1;
    else if (fault == 2 && addr_q == 4'd15 && mem[addr_q] == 8'hA5) rd = rd ^ 8'h01;
  end
  assign bus.ram_data_out = rd;

  typedef struct {
    logic       pass;
    logic [5:0] ec;
    logic [3:0] ffa;
    logic       ffv;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   since = 0;
  int   busy_n = 0;
  bit   armed = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: tracks cycles since the accepted start and checks every done pulse.
  always @(negedge clk) begin
    if (reset) begin
      armed  = 1'b0;
      busy_n = 0;
    end else begin
      if (armed) since++;
      if (armed && busy) busy_n++;
      if (armed && since == 1) begin
        chk("wr_en_a0_p0", bus.ram_write_en, 1);
        chk("wr_addr_a0_p0", bus.ram_address, 0);
        chk("wr_data_a0_p0", bus.ram_data_in, 8'hA5);
      end
      if (armed && since == 4) begin
        chk("wr_addr_a3_p0", bus.ram_address, 3);
        chk("wr_data_a3_p0", bus.ram_data_in, 8'h96);
      end
      if (armed && since == 36) begin
        chk("wr_addr_a3_p1", bus.ram_address, 3);
        chk("wr_data_a3_p1", bus.ram_data_in, 8'h69);
      end
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          mon_e = sb.pop_front();
          chk("done_cycle", since, 66);
          chk("busy_cycles", busy_n, 65);
          chk("pass", pass, mon_e.pass);
          chk("error_count", error_count, mon_e.ec);
          chk("first_fail_addr", first_fail_addr, mon_e.ffa);
          chk("first_fail_valid", first_fail_valid, mon_e.ffv);
        end
        armed = 1'b0;
      end
      if (start && !busy && !done) begin
        armed  = 1'b1;
        since  = 0;
        busy_n = 0;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int tgt;
    int n;
    tgt = done_cnt + 1;
    n = 0;
    while (done_cnt < tgt && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt < tgt) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=%0d required=%0d", done_cnt, tgt);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic run(input int f, input exp_t e);
    fault = f;
    sb.push_back(e);
    pulse_start();
    wait_done();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_error_count", error_count, 0);
    chk("rst_ffa", first_fail_addr, 0);
    chk("rst_ffv", first_fail_valid, 0);
    chk("rst_wr_en", bus.ram_write_en, 0);
    chk("rst_addr", bus.ram_address, 0);
    chk("rst_data_in", bus.ram_data_in, 0);
    reset = 1'b0;

    run(0, '{1'b1, 6'd0,  4'd0,  1'b0});
    run(1, '{1'b0, 6'd16, 4'd1,  1'b1});
    run(2, '{1'b0, 6'd1,  4'd15, 1'b1});

    // Start pulsed mid-run must not disturb timing or results.
    fault = 0;
    sb.push_back('{1'b1, 6'd0, 4'd0, 1'b0});
    pulse_start();
    repeat (19) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();

    // Reset in the middle of a faulty run: results cleared, no done.
    fault = 1;
    pulse_start();
    repeat (39) @(posedge clk);
    chk("pre_reset_error_count", error_count, 8);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr_en", bus.ram_write_en, 0);
    chk("mid_rst_error_count", error_count, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ffv", first_fail_valid, 0);
    reset = 1'b0;
    fault = 0;
    repeat (80) @(posedge clk);
    chk("no_done_after_reset", done_cnt, 4);

    run(0, '{1'b1, 6'd0, 4'd0, 1'b0});
    chk("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
